// File: rtl/npu_sigmoid_pipe.sv
// Three-stage elastic activation unit: sigmoid / tanh / saturating linear / step
// on a wide signed accumulator, producing a signed OUT_FRAC fixed-point result.
module npu_sigmoid_pipe #(
    parameter int IN_W     = 48,
    parameter int IN_FRAC  = 16,
    parameter int OUT_W    = 16,
    parameter int OUT_FRAC = 14
) (
    input  logic             CLK,
    input  logic             npu_rst_n,
    input  logic [IN_W-1:0]  npu_sigmoid_din,
    input  logic [1:0]       npu_sigmoid_fsel,
    input  logic             npu_sigmoid_in_valid,
    output logic             npu_sigmoid_in_ready,
    output logic [OUT_W-1:0] npu_sigmoid_dout,
    output logic             npu_sigmoid_out_valid,
    input  logic             npu_sigmoid_out_ready
);

    typedef enum logic [1:0] {
        MODE_SIG  = 2'b00,
        MODE_TANH = 2'b01,
        MODE_LIN  = 2'b10,
        MODE_STEP = 2'b11
    } mode_e;

    // a spans [0, 8.0] inclusive, so it needs 4 integer bits
    localparam int A_W   = OUT_FRAC + 4;
    localparam int X_W   = IN_W + 2;
    localparam int Y_W   = A_W + OUT_W + 2;
    localparam int SHIFT = IN_FRAC - OUT_FRAC;

    localparam logic [A_W-1:0] ONE   = A_W'(1) << OUT_FRAC;
    localparam logic [A_W-1:0] HALF  = ONE >> 1;
    localparam logic [A_W-1:0] BRK2  = A_W'((19 << OUT_FRAC) >> 3);
    localparam logic [A_W-1:0] BRK3  = A_W'(5 << OUT_FRAC);
    localparam logic [A_W-1:0] OFF2  = A_W'((5 << OUT_FRAC) >> 3);
    localparam logic [A_W-1:0] OFF3  = A_W'((27 << OUT_FRAC) >> 5);
    localparam logic [A_W-1:0] A_SAT = A_W'(8 << OUT_FRAC);

    localparam logic signed [Y_W-1:0] Y_MAX = Y_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [Y_W-1:0] Y_MIN = -Y_MAX - 1;

    logic             v1, v2, v3;
    logic             s1, s2;
    mode_e            f1, f2;
    logic [A_W-1:0]   a1, a2;
    logic [A_W-1:0]   m2;
    logic [OUT_W-1:0] dout_q;

    logic hold1, hold2, hold3;

    always_comb begin
        hold3 = v3 & ~npu_sigmoid_out_ready;
        hold2 = v2 & hold3;
        hold1 = v1 & hold2;
    end

    assign npu_sigmoid_in_ready  = ~hold1;
    assign npu_sigmoid_out_valid = v3;
    assign npu_sigmoid_dout      = dout_q;

    // S1: magnitude with two guard bits so doubling the most negative input cannot wrap
    logic signed [X_W-1:0] x_ext;
    logic signed [X_W-1:0] x_scaled;
    logic [X_W-1:0]        x_mag;
    logic [X_W-1:0]        x_trunc;
    logic [A_W-1:0]        a_next;

    always_comb begin
        x_ext    = {{2{npu_sigmoid_din[IN_W-1]}}, npu_sigmoid_din};
        x_scaled = (mode_e'(npu_sigmoid_fsel) == MODE_TANH) ? (x_ext <<< 1) : x_ext;
        x_mag    = x_scaled[X_W-1] ? unsigned'(-x_scaled) : unsigned'(x_scaled);
        x_trunc  = x_mag >> SHIFT;
        a_next   = (x_trunc >= X_W'(A_SAT)) ? A_SAT : x_trunc[A_W-1:0];
    end

    // S2: piecewise-linear magnitude curve, output in [0.5, 1.0]
    logic [A_W-1:0] m_next;

    always_comb begin
        if (a1 < ONE) begin
            m_next = (a1 >> 2) + HALF;
        end else if (a1 < BRK2) begin
            m_next = (a1 >> 3) + OFF2;
        end else if (a1 < BRK3) begin
            m_next = (a1 >> 5) + OFF3;
        end else begin
            m_next = ONE;
        end
    end

    // S3: every mode funnels through one saturator; only linear can actually exceed range
    logic signed [Y_W-1:0] a_wide;
    logic signed [Y_W-1:0] m_wide;
    logic signed [Y_W-1:0] one_wide;
    logic signed [Y_W-1:0] p_wide;
    logic signed [Y_W-1:0] y_wide;
    logic [OUT_W-1:0]      y_next;

    always_comb begin
        a_wide   = signed'(Y_W'(a2));
        m_wide   = signed'(Y_W'(m2));
        one_wide = signed'(Y_W'(ONE));
        p_wide   = s2 ? (one_wide - m_wide) : m_wide;
        y_wide   = '0;
        unique case (f2)
            MODE_SIG:  y_wide = p_wide;
            MODE_TANH: y_wide = (p_wide <<< 1) - one_wide;
            MODE_LIN:  y_wide = s2 ? -a_wide : a_wide;
            MODE_STEP: y_wide = s2 ? '0 : one_wide;
            default:   y_wide = '0;
        endcase
        if (y_wide > Y_MAX) begin
            y_next = OUT_W'(Y_MAX);
        end else if (y_wide < Y_MIN) begin
            y_next = OUT_W'(Y_MIN);
        end else begin
            y_next = y_wide[OUT_W-1:0];
        end
    end

    always_ff @(posedge CLK or negedge npu_rst_n) begin
        if (!npu_rst_n) begin
            v1     <= 1'b0;
            s1     <= 1'b0;
            f1     <= MODE_SIG;
            a1     <= '0;
            v2     <= 1'b0;
            s2     <= 1'b0;
            f2     <= MODE_SIG;
            a2     <= '0;
            m2     <= '0;
            v3     <= 1'b0;
            dout_q <= '0;
        end else begin
            if (!hold1) begin
                v1 <= npu_sigmoid_in_valid;
                s1 <= npu_sigmoid_din[IN_W-1];
                f1 <= mode_e'(npu_sigmoid_fsel);
                a1 <= a_next;
            end
            if (!hold2) begin
                v2 <= v1;
                s2 <= s1;
                f2 <= f1;
                a2 <= a1;
                m2 <= m_next;
            end
            if (!hold3) begin
                v3     <= v2;
                dout_q <= y_next;
            end
        end
    end

endmodule

// File: tb/tb_npu_sigmoid_pipe.sv
// Scoreboard bench for npu_sigmoid_pipe: directed vectors with hand-computed results.
module tb_npu_sigmoid_pipe;

    logic        CLK = 1'b0;
    logic        npu_rst_n = 1'b0;
    logic [47:0] din = '0;
    logic [1:0]  fsel = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dout;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    int          valid_cycles = 0;
    int          xfers = 0;
    logic        held = 1'b0;
    logic [15:0] held_val = '0;

    npu_sigmoid_pipe dut (
        .CLK                   (CLK),
        .npu_rst_n             (npu_rst_n),
        .npu_sigmoid_din       (din),
        .npu_sigmoid_fsel      (fsel),
        .npu_sigmoid_in_valid  (in_valid),
        .npu_sigmoid_in_ready  (in_ready),
        .npu_sigmoid_dout      (dout),
        .npu_sigmoid_out_valid (out_valid),
        .npu_sigmoid_out_ready (out_ready)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Called at a falling edge; handshake is judged 1 time unit before the rising edge.
    task automatic send(input logic [47:0] d, input logic [1:0] f, input logic [15:0] e);
        int  n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        din      = d;
        fsel     = f;
        in_valid = 1'b1;
        while (!acc && n < 100) begin
            #4;
            acc = in_ready;
            if (acc) exp_q.push_back(e);
            @(negedge CLK);
            n++;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        repeat (3) @(negedge CLK);
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    // Monitor: compares every transferred output against the head of the queue
    initial forever begin
        @(negedge CLK);
        #4;
        if (!npu_rst_n) begin
            held = 1'b0;
        end else begin
            if (out_valid) valid_cycles++;
            if (held && out_valid) check("stall_stable", dout, held_val);
            held     = out_valid && !out_ready;
            held_val = dout;
            if (out_valid && out_ready) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=0x%04h required=none", dout);
                end else begin
                    check("dout", dout, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        bit saw_low;
        int x0;

        repeat (3) @(negedge CLK);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_dout", dout, 16'h0000);
        npu_rst_n = 1'b1;
        #4;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid_rel", out_valid, 1'b0);
        @(negedge CLK);

        // Sigmoid stream: 0, 1.0, -1.0, 8.0, -8.0
        out_ready = 1'b1;
        valid_cycles = 0;
        send(48'h0000_0000_0000, 2'b00, 16'h2000);
        send(48'h0000_0001_0000, 2'b00, 16'h3000);
        send(48'hFFFF_FFFF_0000, 2'b00, 16'h1000);
        send(48'h0000_0008_0000, 2'b00, 16'h4000);
        send(48'hFFFF_FFF8_0000, 2'b00, 16'h0000);
        drain();
        check("sig_valid_cycles", valid_cycles, 32'd5);

        // Sigmoid segment boundaries around 2.375 and 5.0
        send(48'h0000_0002_5FFC, 2'b00, 16'h3AFF);
        send(48'h0000_0002_6000, 2'b00, 16'h3AC0);
        send(48'h0000_0004_FFFC, 2'b00, 16'h3FFF);
        send(48'h0000_0005_0000, 2'b00, 16'h4000);
        send(48'hFFFF_FFFF_8000, 2'b00, 16'h1800);

        // Tanh: 0, 0.5, 8.0, -8.0
        send(48'h0000_0000_0000, 2'b01, 16'h0000);
        send(48'h0000_0000_8000, 2'b01, 16'h2000);
        send(48'h0000_0008_0000, 2'b01, 16'h4000);
        send(48'hFFFF_FFF8_0000, 2'b01, 16'hC000);

        // Linear: 3.0, -0.5, most negative; step: -1.0, 0
        send(48'h0000_0003_0000, 2'b10, 16'h7FFF);
        send(48'hFFFF_FFFF_8000, 2'b10, 16'hE000);
        send(48'h8000_0000_0000, 2'b10, 16'h8000);
        send(48'hFFFF_FFFF_0000, 2'b11, 16'h0000);
        send(48'h0000_0000_0000, 2'b11, 16'h4000);
        drain();

        // Alternating modes, din = 1.0; tanh sees a = 2.0 -> m = 0.875 -> y = 0.75
        send(48'h0000_0001_0000, 2'b00, 16'h3000);
        send(48'h0000_0001_0000, 2'b01, 16'h3000);
        send(48'h0000_0001_0000, 2'b10, 16'h4000);
        send(48'h0000_0001_0000, 2'b11, 16'h4000);
        drain();

        // Back-pressure: 6 sigmoid samples, out_ready low for 4 cycles mid-stream
        x0 = xfers;
        saw_low = 1'b0;
        fork
            begin
                send(48'h0000_0000_0000, 2'b00, 16'h2000);
                send(48'h0000_0001_0000, 2'b00, 16'h3000);
                send(48'hFFFF_FFFF_0000, 2'b00, 16'h1000);
                send(48'h0000_0008_0000, 2'b00, 16'h4000);
                send(48'hFFFF_FFF8_0000, 2'b00, 16'h0000);
                send(48'h0000_0000_8000, 2'b00, 16'h2800);
            end
            begin
                repeat (3) @(negedge CLK);
                out_ready = 1'b0;
                repeat (4) begin
                    #4;
                    if (!in_ready) saw_low = 1'b1;
                    @(negedge CLK);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_in_ready_low", saw_low, 1'b1);
        check("bp_xfers", xfers - x0, 32'd6);

        // Reset with 3 samples in flight
        out_ready = 1'b0;
        send(48'h0000_0001_0000, 2'b00, 16'h3000);
        send(48'h0000_0001_0000, 2'b01, 16'h3000);
        send(48'h0000_0001_0000, 2'b10, 16'h4000);
        check("full_out_valid", out_valid, 1'b1);
        #2;
        npu_rst_n = 1'b0;
        #1;
        check("async_out_valid", out_valid, 1'b0);
        check("async_dout", dout, 16'h0000);
        exp_q.delete();
        repeat (2) @(negedge CLK);
        npu_rst_n = 1'b1;
        out_ready = 1'b1;
        valid_cycles = 0;
        repeat (5) @(negedge CLK);
        check("no_stale_output", valid_cycles, 32'd0);

        // Latency after reset: sigmoid 0.5 -> 0.625
        din      = 48'h0000_0000_8000;
        fsel     = 2'b00;
        in_valid = 1'b1;
        #4;
        check("post_rst_in_ready", in_ready, 1'b1);
        if (in_ready) exp_q.push_back(16'h2800);
        @(negedge CLK);
        in_valid = 1'b0;
        #4;
        check("lat_cycle1", out_valid, 1'b0);
        @(negedge CLK);
        #4;
        check("lat_cycle2", out_valid, 1'b0);
        @(negedge CLK);
        #4;
        check("lat_cycle3", out_valid, 1'b1);
        @(negedge CLK);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
